// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write bypass, pending scoreboard and init sweep
//
// Purpose: NRD combinational read ports, two write ports (A: ALU writeback,
// B: load/late writeback, B wins on address collision), same-cycle write-to-read
// bypass, a per-entry pending scoreboard for decode stalls, and a post-reset
// sweep that zeroes the storage array so it needs no reset of its own.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   ready                 0 during the init sweep, 1 in RUN
//   rd_addr / rd_data     packed read ports, port k at [k*AW +: AW] / [k*XLEN +: XLEN]
//   rd_pending            scoreboard bit per read port, masked by same-cycle writes
//   wa_en/addr/data       write port A
//   wb_en/addr/data       write port B
//   rsv_en, rsv_addr      mark an entry as having an outstanding writer
//   busy                  OR of all pending bits
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pending,
  input  logic                wa_en,
  input  logic [AW-1:0]       wa_addr,
  input  logic [XLEN-1:0]     wa_data,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                busy
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state;
  logic [AW-1:0]     clr_cnt;
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;
  logic [XLEN-1:0]   mem [NREG];

  logic run;
  logic wa_zero, wb_zero, rsv_zero;
  logic wa_we, wb_we, rsv_we;

  assign run      = (state == S_RUN);
  assign wa_zero  = (ZERO_REG != 0) && (wa_addr == '0);
  assign wb_zero  = (ZERO_REG != 0) && (wb_addr == '0);
  assign rsv_zero = (ZERO_REG != 0) && (rsv_addr == '0);

  // rst is folded in so a write coinciding with reset assertion is discarded
  // even before the asynchronous state change is seen by the array block.
  assign wb_we  = run && !rst && wb_en && !wb_zero;
  assign wa_we  = run && !rst && wa_en && !wa_zero && !(wb_en && (wb_addr == wa_addr));
  assign rsv_we = run && !rst && rsv_en && !rsv_zero;

  // Reserve is applied last so it wins over a same-cycle write to that entry.
  always_comb begin
    pending_nxt = pending;
    if (wa_we)  pending_nxt[wa_addr]  = 1'b0;
    if (wb_we)  pending_nxt[wb_addr]  = 1'b0;
    if (rsv_we) pending_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_INIT;
      clr_cnt <= '0;
      pending <= '0;
    end else if (state == S_INIT) begin
      clr_cnt <= clr_cnt + AW'(1);
      if (clr_cnt == AW'(NREG - 1)) state <= S_RUN;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Storage has no reset so it can map onto distributed RAM; the sweep zeroes it.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (wa_we) mem[wa_addr] <= wa_data;
      if (wb_we) mem[wb_addr] <= wb_data;
    end
  end

  logic [AW-1:0]   ra;
  logic [XLEN-1:0] rv;

  always_comb begin
    rd_data    = '0;
    rd_pending = '0;
    ra         = '0;
    rv         = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr[k*AW +: AW];
      if ((ZERO_REG != 0) && (ra == '0))  rv = '0;
      else if (wb_en && (wb_addr == ra))  rv = wb_data;
      else if (wa_en && (wa_addr == ra))  rv = wa_data;
      else                                rv = mem[ra];
      if (run) begin
        rd_data[k*XLEN +: XLEN] = rv;
        // A same-cycle write supplies the value via bypass, so no stall is needed.
        rd_pending[k] = pending[ra] && !(wa_en && (wa_addr == ra)) && !(wb_en && (wb_addr == ra));
      end
    end
  end

  assign ready = run;
  assign busy  = |pending;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default configuration: NREG=32, NRD=2, XLEN=32, ZERO_REG=1
  logic        rst, ready, busy;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pending;
  logic        wa_en, wb_en, rsv_en;
  logic [4:0]  wa_addr, wb_addr, rsv_addr;
  logic [31:0] wa_data, wb_data;

  // swept configuration: NREG=8, NRD=4, XLEN=16, ZERO_REG=0
  logic        rst2, ready2, busy2;
  logic [11:0] rd_addr2;
  logic [63:0] rd_data2;
  logic [3:0]  rd_pending2;
  logic        wa_en2, wb_en2, rsv_en2;
  logic [2:0]  wa_addr2, wb_addr2, rsv_addr2;
  logic [15:0] wa_data2, wb_data2;

  regfile_mp u_dut (
    .clk(clk), .rst(rst), .ready(ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy(busy)
  );

  regfile_mp #(.XLEN(16), .NREG(8), .NRD(4), .ZERO_REG(0)) u_dut2 (
    .clk(clk), .rst(rst2), .ready(ready2),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_pending(rd_pending2),
    .wa_en(wa_en2), .wa_addr(wa_addr2), .wa_data(wa_data2),
    .wb_en(wb_en2), .wb_addr(wb_addr2), .wb_data(wb_data2),
    .rsv_en(rsv_en2), .rsv_addr(rsv_addr2), .busy(busy2)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] model [32];
  logic [15:0] model2 [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1;
    repeat (3) tick();
    exp_q.push_back(32'h0);  // {ready,busy,rd_pending}
    exp_q.push_back(32'h0);  // rd_data low
    exp_q.push_back(32'h0);  // rd_data high
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({29'b0, ready, busy, rd_pending} !== exp_v) begin
      failures++; $display("FAIL reset_flags got=%h exp=%h", {ready, busy, rd_pending}, exp_v);
    end
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data[31:0] !== exp_v) begin
      failures++; $display("FAIL reset_rd0 got=%h exp=%h", rd_data[31:0], exp_v);
    end
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data[63:32] !== exp_v) begin
      failures++; $display("FAIL reset_rd1 got=%h exp=%h", rd_data[63:32], exp_v);
    end
    tick();
    rst = 1'b0;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt !== 32) begin
      failures++; $display("FAIL init_sweep_len got=%0d exp=32", cnt);
    end
    for (int i = 0; i < 32; i += 2) begin
      rd_addr = {5'(i + 1), 5'(i)};
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      @(negedge clk);
      exp_v = exp_q.pop_front(); checks++;
      if (rd_data[31:0] !== exp_v) begin
        failures++; $display("FAIL init_zero addr=%0d got=%h exp=%h", i, rd_data[31:0], exp_v);
      end
      exp_v = exp_q.pop_front(); checks++;
      if (rd_data[63:32] !== exp_v) begin
        failures++; $display("FAIL init_zero addr=%0d got=%h exp=%h", i + 1, rd_data[63:32], exp_v);
      end
    end
    tick();
  endtask

  task automatic test_bypass();
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
    rd_addr = {5'd0, 5'd5};
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data[31:0] !== exp_v) begin
      failures++; $display("FAIL bypass_same_cycle got=%h exp=%h", rd_data[31:0], exp_v);
    end
    tick();
    wa_en = 1'b0;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data[31:0] !== exp_v) begin
      failures++; $display("FAIL array_after_write got=%h exp=%h", rd_data[31:0], exp_v);
    end
    tick();
  endtask

  task automatic test_collision();
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h1111;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h2222;
    rd_addr = {5'd7, 5'd7};
    exp_q.push_back(32'h2222);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data[63:32] !== exp_v) begin
      failures++; $display("FAIL collision_bypass got=%h exp=%h", rd_data[63:32], exp_v);
    end
    tick();
    wa_en = 1'b0; wb_en = 1'b0;
    exp_q.push_back(32'h2222);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data[31:0] !== exp_v) begin
      failures++; $display("FAIL collision_b_wins got=%h exp=%h", rd_data[31:0], exp_v);
    end
    tick();
    // address 0 is hardwired when ZERO_REG=1, via either port
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'h5;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h5;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    rd_addr = {5'd0, 5'd0};
    exp_q.push_back(32'h0);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data[31:0] !== exp_v) begin
      failures++; $display("FAIL zero_reg_bypass got=%h exp=%h", rd_data[31:0], exp_v);
    end
    tick();
    wa_en = 1'b0; wb_en = 1'b0; rsv_en = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);  // {busy, rd_pending}
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if (rd_data[31:0] !== exp_v) begin
      failures++; $display("FAIL zero_reg_array got=%h exp=%h", rd_data[31:0], exp_v);
    end
    exp_v = exp_q.pop_front(); checks++;
    if ({29'b0, busy, rd_pending} !== exp_v) begin
      failures++; $display("FAIL zero_reg_rsv got=%h exp=%h", {busy, rd_pending}, exp_v);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    rd_addr = {5'd1, 5'd9};
    exp_q.push_back(32'h0);  // not visible in the reserve cycle
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({30'b0, rd_pending} !== exp_v) begin
      failures++; $display("FAIL rsv_same_cycle got=%h exp=%h", rd_pending, exp_v);
    end
    tick();
    rsv_en = 1'b0;
    exp_q.push_back(32'h3);  // {busy, rd_pending[0]}
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({30'b0, busy, rd_pending[0]} !== exp_v) begin
      failures++; $display("FAIL rsv_visible got=%h exp=%h", {busy, rd_pending[0]}, exp_v);
    end
    tick();
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    exp_q.push_back(32'h2);  // busy still 1, rd_pending masked
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({30'b0, busy, rd_pending[0]} !== exp_v) begin
      failures++; $display("FAIL write_masks_pending got=%h exp=%h", {busy, rd_pending[0]}, exp_v);
    end
    tick();
    wb_en = 1'b0;
    exp_q.push_back(32'h0);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({30'b0, busy, rd_pending[0]} !== exp_v) begin
      failures++; $display("FAIL write_clears_pending got=%h exp=%h", {busy, rd_pending[0]}, exp_v);
    end
    tick();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h77;
    tick();
    rsv_en = 1'b0; wa_en = 1'b0;
    exp_q.push_back(32'h3);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({30'b0, busy, rd_pending[0]} !== exp_v) begin
      failures++; $display("FAIL rsv_beats_write got=%h exp=%h", {busy, rd_pending[0]}, exp_v);
    end
    tick();
    wa_en = 1'b1; wa_addr = 5'd9; wa_data = 32'h78;
    tick();
    wa_en = 1'b0;
  endtask

  task automatic test_midreset();
    int cnt;
    for (int i = 1; i < 32; i++) begin
      model[i] = 32'h1000_0000 + i * 32'h0001_0203;
      wa_en = 1'b1; wa_addr = 5'(i); wa_data = model[i];
      tick();
    end
    wa_en = 1'b0;
    for (int i = 1; i < 32; i++) begin
      rd_addr = {5'd0, 5'(i)};
      exp_q.push_back(model[i]);
      #1;
      exp_v = exp_q.pop_front(); checks++;
      if (rd_data[31:0] !== exp_v) begin
        failures++; $display("FAIL fill_readback addr=%0d got=%h exp=%h", i, rd_data[31:0], exp_v);
      end
    end
    rsv_en = 1'b1; rsv_addr = 5'd3;
    tick();
    rsv_en = 1'b0;
    rd_addr = {5'd3, 5'd3};
    rst = 1'b1;
    exp_q.push_back(32'h0);  // {ready, busy, rd_pending}
    #1;
    exp_v = exp_q.pop_front(); checks++;
    if ({28'b0, ready, busy, rd_pending} !== exp_v) begin
      failures++; $display("FAIL midrst_flags got=%h exp=%h", {ready, busy, rd_pending}, exp_v);
    end
    rst = 1'b0;
    wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h1234;
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h5678;
    rsv_en = 1'b1; rsv_addr = 5'd8;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    wa_en = 1'b0; wb_en = 1'b0; rsv_en = 1'b0;
    checks++;
    if (cnt !== 32) begin
      failures++; $display("FAIL midrst_sweep_len got=%0d exp=32", cnt);
    end
    exp_q.push_back(32'h0);
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({31'b0, busy} !== exp_v) begin
      failures++; $display("FAIL init_rsv_ignored got=%h exp=%h", busy, exp_v);
    end
    for (int i = 0; i < 32; i += 2) begin
      rd_addr = {5'(i + 1), 5'(i)};
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      #1;
      exp_v = exp_q.pop_front(); checks++;
      if (rd_data[31:0] !== exp_v) begin
        failures++; $display("FAIL midrst_zero addr=%0d got=%h exp=%h", i, rd_data[31:0], exp_v);
      end
      exp_v = exp_q.pop_front(); checks++;
      if (rd_data[63:32] !== exp_v) begin
        failures++; $display("FAIL midrst_zero addr=%0d got=%h exp=%h", i + 1, rd_data[63:32], exp_v);
      end
    end
    tick();
  endtask

  task automatic test_param_sweep();
    int cnt;
    logic [2:0] a;
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    cnt = 0;
    while (ready2 !== 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt !== 8) begin
      failures++; $display("FAIL p2_sweep_len got=%0d exp=8", cnt);
    end
    model2[0] = 16'hABCD;
    wa_en2 = 1'b1; wa_addr2 = 3'd0; wa_data2 = model2[0];
    tick();
    wa_en2 = 1'b0;
    rd_addr2 = 12'h0;
    exp_q.push_back({16'h0, model2[0]});
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({16'h0, rd_data2[15:0]} !== exp_v) begin
      failures++; $display("FAIL p2_addr0_write got=%h exp=%h", rd_data2[15:0], exp_v);
    end
    tick();
    for (int i = 1; i < 8; i++) begin
      model2[i] = 16'h1000 + 16'(i * 16'h0111);
      wb_en2 = 1'b1; wb_addr2 = 3'(i); wb_data2 = model2[i];
      tick();
    end
    wb_en2 = 1'b0;
    for (int pat = 0; pat < 2; pat++) begin
      rd_addr2 = (pat == 0) ? {3'd7, 3'd5, 3'd3, 3'd0} : {3'd6, 3'd4, 3'd2, 3'd1};
      for (int k = 0; k < 4; k++) begin
        a = rd_addr2[k*3 +: 3];
        exp_q.push_back({16'h0, model2[a]});
      end
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        exp_v = exp_q.pop_front(); checks++;
        if ({16'h0, rd_data2[k*16 +: 16]} !== exp_v) begin
          failures++; $display("FAIL p2_port%0d pat%0d got=%h exp=%h", k, pat, rd_data2[k*16 +: 16], exp_v);
        end
      end
      tick();
    end
    rsv_en2 = 1'b1; rsv_addr2 = 3'd0;
    tick();
    rsv_en2 = 1'b0;
    rd_addr2 = 12'h0;
    exp_q.push_back(32'h1F);  // {busy2, rd_pending2}
    @(negedge clk);
    exp_v = exp_q.pop_front(); checks++;
    if ({27'b0, busy2, rd_pending2} !== exp_v) begin
      failures++; $display("FAIL p2_rsv_addr0 got=%h exp=%h", {busy2, rd_pending2}, exp_v);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    rd_addr = '0; wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; rsv_en = 1'b0; rsv_addr = '0;
    rd_addr2 = '0; wa_en2 = 1'b0; wa_addr2 = '0; wa_data2 = '0;
    wb_en2 = 1'b0; wb_addr2 = '0; wb_data2 = '0; rsv_en2 = 1'b0; rsv_addr2 = '0;
    test_reset();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_midreset();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined core, replacing the fixed 32x32 two-read/one-write file. It provides NRD combinational read ports, two write ports (A: ALU writeback, B: load/late writeback) and same-cycle write-to-read bypass. A per-entry pending scoreboard lets decode stall on outstanding writers. After reset, a sweep state machine clears the storage array so it can map onto distributed RAM.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of entries; power of two, at least 2
- NRD, 2, number of read ports, 1 to 4
- ZERO_REG, 1, when 1 entry 0 reads as 0 and ignores writes and reserves
- AW (localparam), $clog2(NREG), address width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- ready  out  1  0 during the init sweep, 1 in RUN
- rd_addr  in  NRD*AW  read addresses; port k is bits [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port k is bits [k*XLEN +: XLEN]
- rd_pending  out  NRD  scoreboard bit of each read address
- wa_en, wa_addr, wa_data  in  1/AW/XLEN  write port A
- wb_en, wb_addr, wb_data  in  1/AW/XLEN  write port B
- rsv_en, rsv_addr  in  1/AW  reserve an entry as pending (issue of a writer)
- busy  out  1  OR of all pending bits

## Operation
- State machine states:
  - INIT: entered asynchronously on rst. clr_cnt is reset to 0. Each cycle writes 0 to mem[clr_cnt] and increments clr_cnt. After the cycle that clears entry NREG-1, moves to RUN. Never re-entered except through rst.
  - RUN: normal operation.
- In INIT:
  - ready=0 and rd_data=0.
  - Write and reserve inputs are ignored.
  - rd_pending=0.
- Write, RUN only: on a rising edge, wX_en=1 writes wX_data to mem[wX_addr].
  - If wa_addr==wb_addr and both enables are 1, B wins and the A write is dropped.
  - If ZERO_REG=1, writes to address 0 are dropped.
- Read, combinational: rd_data[k] = mem[rd_addr[k]], with bypass priority:
  - address 0 with ZERO_REG=1 returns 0, highest priority;
  - else a matching enabled wb returns wb_data;
  - else a matching enabled wa returns wa_data;
  - else the array value.
- Scoreboard: pending[NREG-1:0] is a flop vector.
  - An enabled write (A or B) to entry i clears pending[i].
  - rsv_en sets pending[rsv_addr].
  - Reserve and write to the same entry in the same cycle: the reserve wins and pending stays 1, because a new writer is outstanding.
  - Reserve to 0 with ZERO_REG=1 is ignored.
- rd_pending[k] = pending[rd_addr[k]] AND NOT (a write to that address in the same cycle). The bypassed value is valid, so decode does not stall.
- busy = |pending.
- Widths: addresses are exactly AW bits, so out-of-range addresses cannot occur. No arithmetic is done on the data path.

## Timing
- Reset values: ready=0, busy=0, rd_pending=0, rd_data=0, state=INIT, clr_cnt=0, pending all 0.
- Init sweep takes NREG cycles after rst deasserts. ready rises on the edge that completes entry NREG-1, so the first RUN cycle is cycle NREG.
- Write latency: 0 cycles to read ports (bypass), 1 edge to the array.
- Reserve latency: pending is visible on rd_pending the cycle after rsv_en.
- rst asserted mid-operation:
  - immediate return to INIT;
  - pending is cleared;
  - any write in flight on that edge is discarded;
  - a full NREG-cycle sweep is repeated.
- All outputs are combinational from flops, array and current inputs. There are no registered read paths.

## Test plan
- Reset/init, NREG=32: assert rst for 3 cycles, then release. ready=0 for exactly 32 cycles, then 1. Every address reads 0.
- Write/read plus bypass: in RUN, wa writes 0xDEADBEEF to address 5 while rd_addr[0]=5. rd_data[0]=0xDEADBEEF in the same cycle and on the next cycle with wa_en=0.
- Dual-write collision: wa writes (7, 0x1111) and wb writes (7, 0x2222) on the same edge. The next cycle reads 0x2222. Write 0x5 to address 0: address 0 still reads 0.
- Scoreboard:
  - rsv address 9: rd_pending=1 and busy=1 on the next cycle.
  - wb write to 9: rd_pending=0 in that cycle, busy=0 afterwards.
  - Simultaneous rsv 9 and wa write 9: pending remains 1.
- Reset mid-operation: fill addresses 1-31 with nonzero values, reserve address 3, then pulse rst. Pending clears immediately and ready=0. After 32 cycles all entries read 0 and writes issued during INIT have no effect.
- Parameter sweep: NREG=8, NRD=4, XLEN=16, ZERO_REG=0. Address 0 is writable (0xABCD read back), all 4 ports read independent addresses correctly, and the init sweep lasts 8 cycles.
